// File: rtl/aes_hpc_word_loader_pkg.sv
// Shared encodings and packet-length helpers for the masked AES word loader.
package aes_hpc_word_loader_pkg;

    typedef enum logic [1:0] {
        CMD_PT   = 2'b00,
        CMD_KEY  = 2'b01,
        CMD_SEED = 2'b10,
        CMD_BAD  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_PT,
        ST_LOAD_KEY,
        ST_LOAD_SEED,
        ST_SEND_AES,
        ST_SEND_SEED,
        ST_DRAIN
    } state_t;

    localparam int SEED_W = 80;

    function automatic int pw_words(input int shares);
        return 4 * shares;
    endfunction

    function automatic int kw_words(input int shares);
        return 8 * shares;
    endfunction

    function automatic int sw_words();
        return 3;
    endfunction

endpackage

// File: rtl/aes_hpc_word_loader_word_slot_reg.sv
// Word-addressed register of WIDTH bits, written 32 bits at a time; the top word
// may be partial, in which case the upper bits of the written word are dropped.
module aes_hpc_word_loader_word_slot_reg #(
    parameter int WIDTH = 128,
    parameter int IW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IW-1:0]    idx_i,
    input  logic [31:0]      wdata_i,
    output logic [WIDTH-1:0] q_o
);

    localparam int NW = (WIDTH + 31) / 32;

    for (genvar w = 0; w < NW; w++) begin : g_word
        localparam int LO = 32 * w;
        localparam int BW = ((WIDTH - LO) < 32) ? (WIDTH - LO) : 32;

        logic [BW-1:0] word_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                word_q <= '0;
            end else if (we_i && (idx_i == IW'(w))) begin
                word_q <= wdata_i[BW-1:0];
            end
        end

        assign q_o[LO +: BW] = word_q;
    end

endmodule

// File: rtl/aes_hpc_word_loader.sv
// Assembles a 32-bit word stream into shared plaintext, retained shared key and
// PRNG seed, and hands them to the AES core and PRNG over valid/ready.
module aes_hpc_word_loader
    import aes_hpc_word_loader_pkg::*;
#(
    parameter int d = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        s_data,
    input  logic [1:0]         s_cmd,
    input  logic               s_inverse,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [128*d-1:0]   aes_shares_plaintext,
    output logic [256*d-1:0]   aes_shares_key,
    output logic               aes_inverse,
    output logic               aes_valid,
    input  logic               aes_ready,
    output logic [SEED_W-1:0]  seed,
    output logic               seed_valid,
    input  logic               seed_ready,
    output logic               key_loaded,
    output logic               err
);

    localparam int PWN = pw_words(d);
    localparam int KWN = kw_words(d);
    localparam int SWN = sw_words();
    localparam int CW  = $clog2(8 * d + 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          s_ready_q;
    logic          aes_valid_q;
    logic          seed_valid_q;
    logic          key_loaded_q;
    logic          err_q;
    logic          inverse_q;

    cmd_t cmd_in;
    logic hs;
    logic in_idle;
    logic pt_we;
    logic key_we;
    logic seed_we;
    logic pt_last;
    logic key_last;
    logic seed_last;

    assign cmd_in  = cmd_t'(s_cmd);
    assign hs      = s_valid & s_ready_q;
    assign in_idle = (state_q == ST_IDLE);

    // The first word is written in IDLE where cnt is 0, so cnt is always the word index.
    assign pt_we   = hs & ((in_idle & (cmd_in == CMD_PT))   | (state_q == ST_LOAD_PT));
    assign key_we  = hs & ((in_idle & (cmd_in == CMD_KEY))  | (state_q == ST_LOAD_KEY));
    assign seed_we = hs & ((in_idle & (cmd_in == CMD_SEED)) | (state_q == ST_LOAD_SEED));

    assign pt_last   = (cnt_q == CW'(PWN - 1));
    assign key_last  = (cnt_q == CW'(KWN - 1));
    assign seed_last = (cnt_q == CW'(SWN - 1));

    aes_hpc_word_loader_word_slot_reg #(
        .WIDTH (32 * PWN),
        .IW    (CW)
    ) u_pt_slot (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (pt_we),
        .idx_i   (cnt_q),
        .wdata_i (s_data),
        .q_o     (aes_shares_plaintext)
    );

    aes_hpc_word_loader_word_slot_reg #(
        .WIDTH (32 * KWN),
        .IW    (CW)
    ) u_key_slot (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (key_we),
        .idx_i   (cnt_q),
        .wdata_i (s_data),
        .q_o     (aes_shares_key)
    );

    aes_hpc_word_loader_word_slot_reg #(
        .WIDTH (SEED_W),
        .IW    (CW)
    ) u_seed_slot (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (seed_we),
        .idx_i   (cnt_q),
        .wdata_i (s_data),
        .q_o     (seed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            s_ready_q    <= 1'b1;
            aes_valid_q  <= 1'b0;
            seed_valid_q <= 1'b0;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
            inverse_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        cnt_q <= CW'(1);
                        case (cmd_in)
                            CMD_PT: begin
                                state_q   <= ST_LOAD_PT;
                                inverse_q <= s_inverse;
                            end
                            CMD_KEY: begin
                                state_q      <= ST_LOAD_KEY;
                                key_loaded_q <= 1'b0;
                            end
                            CMD_SEED: begin
                                state_q <= ST_LOAD_SEED;
                            end
                            default: begin
                                err_q <= 1'b1;
                                cnt_q <= '0;
                            end
                        endcase
                    end
                end
                ST_LOAD_PT: begin
                    if (hs) begin
                        if (pt_last) begin
                            cnt_q <= '0;
                            if (key_loaded_q) begin
                                state_q     <= ST_SEND_AES;
                                s_ready_q   <= 1'b0;
                                aes_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                                err_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOAD_KEY: begin
                    if (hs) begin
                        if (key_last) begin
                            cnt_q        <= '0;
                            state_q      <= ST_IDLE;
                            key_loaded_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOAD_SEED: begin
                    if (hs) begin
                        if (seed_last) begin
                            cnt_q        <= '0;
                            state_q      <= ST_SEND_SEED;
                            s_ready_q    <= 1'b0;
                            seed_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_SEND_AES: begin
                    if (aes_ready) begin
                        state_q     <= ST_IDLE;
                        s_ready_q   <= 1'b1;
                        aes_valid_q <= 1'b0;
                    end
                end
                ST_SEND_SEED: begin
                    if (seed_ready) begin
                        state_q      <= ST_IDLE;
                        s_ready_q    <= 1'b1;
                        seed_valid_q <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encodings recover to an empty, accepting loader.
                    state_q      <= ST_IDLE;
                    cnt_q        <= '0;
                    s_ready_q    <= 1'b1;
                    aes_valid_q  <= 1'b0;
                    seed_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign aes_valid   = aes_valid_q;
    assign seed_valid  = seed_valid_q;
    assign key_loaded  = key_loaded_q;
    assign err         = err_q;
    assign aes_inverse = inverse_q;

endmodule

// File: tb/tb_aes_hpc_word_loader.sv
// Randomized self-checking bench for aes_hpc_word_loader with a packet-level model.
module tb_aes_hpc_word_loader;

    localparam int D  = 2;
    localparam int PW = 4 * D;
    localparam int KW = 8 * D;
    localparam int PB = 128 * D;
    localparam int KB = 256 * D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   s_data = '0;
    logic [1:0]    s_cmd = '0;
    logic          s_inverse = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PB-1:0] aes_shares_plaintext;
    logic [KB-1:0] aes_shares_key;
    logic          aes_inverse;
    logic          aes_valid;
    logic          aes_ready = 1'b0;
    logic [79:0]   seed;
    logic          seed_valid;
    logic          seed_ready = 1'b0;
    logic          key_loaded;
    logic          err;

    aes_hpc_word_loader #(.d(D)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_data               (s_data),
        .s_cmd                (s_cmd),
        .s_inverse            (s_inverse),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .aes_shares_plaintext (aes_shares_plaintext),
        .aes_shares_key       (aes_shares_key),
        .aes_inverse          (aes_inverse),
        .aes_valid            (aes_valid),
        .aes_ready            (aes_ready),
        .seed                 (seed),
        .seed_valid           (seed_valid),
        .seed_ready           (seed_ready),
        .key_loaded           (key_loaded),
        .err                  (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int nlow    = 0;

    // Packet-level expectation of every output register.
    logic [PB-1:0] exp_pt;
    logic [KB-1:0] exp_key;
    logic [79:0]   exp_seed;
    logic          exp_inv;
    logic          exp_kl;

    logic [31:0] pkt [0:KW-1];
    logic        pkt_inv;

    task automatic chk(input string tag, input logic [KB-1:0] got, input logic [KB-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_pt   = '0;
        exp_key  = '0;
        exp_seed = '0;
        exp_inv  = 1'b0;
        exp_kl   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [1:0] cmd, input logic inv, input int gap);
        int budget;
        s_valid = 1'b0;
        repeat (gap) step();
        s_data    = w;
        s_cmd     = cmd;
        s_inverse = inv;
        s_valid   = 1'b1;
        budget    = 0;
        while (!s_ready && budget < 20) begin
            step();
            budget++;
        end
        if (!s_ready) chk("s_ready_timeout", KB'(0), KB'(1));
        nlow += budget;
        step();
        s_valid = 1'b0;
    endtask

    task automatic check_aes_outputs(input string tag);
        chk({tag, "_aes_valid"}, KB'(aes_valid), KB'(1));
        chk({tag, "_s_ready"},   KB'(s_ready),   KB'(0));
        chk({tag, "_pt"},        KB'(aes_shares_plaintext), KB'(exp_pt));
        chk({tag, "_key"},       aes_shares_key, exp_key);
        chk({tag, "_inv"},       KB'(aes_inverse), KB'(exp_inv));
    endtask

    task automatic release_aes(input int hold);
        aes_ready = 1'b0;
        repeat (hold) begin
            step();
            check_aes_outputs("aes_hold");
        end
        aes_ready = 1'b1;
        step();
        aes_ready = 1'b0;
        chk("aes_valid_drop", KB'(aes_valid), KB'(0));
        chk("aes_idle_ready", KB'(s_ready),   KB'(1));
    endtask

    task automatic release_seed(input int hold);
        seed_ready = 1'b0;
        repeat (hold) begin
            step();
            chk("seed_hold_valid", KB'(seed_valid), KB'(1));
            chk("seed_hold_ready", KB'(s_ready),    KB'(0));
            chk("seed_hold_val",   KB'(seed),       KB'(exp_seed));
        end
        seed_ready = 1'b1;
        step();
        seed_ready = 1'b0;
        chk("seed_valid_drop", KB'(seed_valid), KB'(0));
        chk("seed_idle_ready", KB'(s_ready),    KB'(1));
    endtask

    // kind: 0 plaintext, 1 key, 2 seed, 3 illegal command
    task automatic run_packet(input int kind, input int gap_max, input int hold);
        int len;
        logic [95:0] sw;
        len = (kind == 0) ? PW : (kind == 1) ? KW : (kind == 2) ? 3 : 1;
        for (int w = 0; w < len; w++) begin
            send_word(pkt[w],
                      (w == 0) ? 2'(kind) : 2'($urandom),
                      (w == 0) ? pkt_inv : 1'($urandom),
                      int'($urandom_range(0, gap_max)));
            if (kind == 1 && w == 0) begin
                exp_kl = 1'b0;
                chk("kl_clear_on_key", KB'(key_loaded), KB'(0));
            end
        end
        case (kind)
            0: begin
                for (int w = 0; w < PW; w++) exp_pt[32*w +: 32] = pkt[w];
                exp_inv = pkt_inv;
                if (exp_kl) begin
                    check_aes_outputs("aes_rise");
                    release_aes(hold);
                end else begin
                    chk("nokey_err",       KB'(err),       KB'(1));
                    chk("nokey_aes_valid", KB'(aes_valid), KB'(0));
                    chk("nokey_s_ready",   KB'(s_ready),   KB'(1));
                    chk("nokey_pt",        KB'(aes_shares_plaintext), KB'(exp_pt));
                    step();
                    chk("nokey_err_once",  KB'(err),       KB'(0));
                    chk("nokey_aes_still", KB'(aes_valid), KB'(0));
                end
            end
            1: begin
                for (int w = 0; w < KW; w++) exp_key[32*w +: 32] = pkt[w];
                exp_kl = 1'b1;
                chk("key_loaded", KB'(key_loaded), KB'(1));
                chk("key_value",  aes_shares_key,  exp_key);
                chk("key_err",    KB'(err),        KB'(0));
                chk("key_ready",  KB'(s_ready),    KB'(1));
            end
            2: begin
                sw = {pkt[2], pkt[1], pkt[0]};
                exp_seed = sw[79:0];
                chk("seed_valid", KB'(seed_valid), KB'(1));
                chk("seed_value", KB'(seed),       KB'(exp_seed));
                release_seed(hold);
            end
            default: begin
                chk("bad_err",     KB'(err),     KB'(1));
                chk("bad_s_ready", KB'(s_ready), KB'(1));
                step();
                chk("bad_err_once", KB'(err),    KB'(0));
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int r;
        model_reset();
        pkt_inv = 1'b0;
        for (int w = 0; w < KW; w++) pkt[w] = '0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_s_ready",    KB'(s_ready),    KB'(1));
        chk("rst_aes_valid",  KB'(aes_valid),  KB'(0));
        chk("rst_seed_valid", KB'(seed_valid), KB'(0));
        chk("rst_key_loaded", KB'(key_loaded), KB'(0));
        chk("rst_err",        KB'(err),        KB'(0));
        chk("rst_pt",         KB'(aes_shares_plaintext), KB'(0));
        chk("rst_key",        aes_shares_key,  KB'(0));
        chk("rst_seed",       KB'(seed),       KB'(0));

        // Plaintext with no key loaded
        for (int w = 0; w < PW; w++) pkt[w] = 32'h20 + w;
        pkt_inv = 1'b0;
        run_packet(0, 0, 0);

        // Key 0..15, then plaintext 0x10..0x17 with inverse, held 5 cycles
        for (int w = 0; w < KW; w++) pkt[w] = w;
        run_packet(1, 0, 0);
        for (int w = 0; w < PW; w++) pkt[w] = 32'h10 + w;
        pkt_inv = 1'b1;
        run_packet(0, 0, 5);
        chk("pt_top_word", KB'(aes_shares_plaintext[255:224]), KB'(32'h17));
        chk("key_word0",   KB'(aes_shares_key[31:0]),          KB'(0));
        chk("inverse",     KB'(aes_inverse),                   KB'(1));

        // Seed packet, upper half of word 2 ignored
        pkt[0] = 32'hAAAAAAAA;
        pkt[1] = 32'hBBBBBBBB;
        pkt[2] = 32'hFFFF1234;
        run_packet(2, 0, 3);
        chk("seed_directed", KB'(seed), KB'(80'h1234_BBBBBBBB_AAAAAAAA));

        // Illegal command consumed, then a normal plaintext
        pkt[0] = $urandom;
        run_packet(3, 0, 0);
        for (int w = 0; w < PW; w++) pkt[w] = $urandom;
        pkt_inv = 1'b0;
        run_packet(0, 0, 1);

        // Reset in the middle of a key load
        for (int w = 0; w < 6; w++) send_word($urandom, (w == 0) ? 2'b01 : 2'($urandom), 1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("midrst_kl",      KB'(key_loaded), KB'(0));
        chk("midrst_key",     aes_shares_key,  KB'(0));
        chk("midrst_s_ready", KB'(s_ready),    KB'(1));
        chk("midrst_valid",   KB'(aes_valid),  KB'(0));
        for (int w = 0; w < KW; w++) pkt[w] = 32'h100 + w;
        run_packet(1, 0, 0);
        for (int w = 0; w < PW; w++) pkt[w] = $urandom;
        pkt_inv = 1'b1;
        run_packet(0, 1, 0);

        // Back-to-back plaintexts with s_valid and aes_ready held high
        aes_ready = 1'b1;
        nlow = 0;
        c0 = cyc;
        for (int p = 0; p < 2; p++) begin
            for (int w = 0; w < PW; w++) begin
                pkt[w] = 32'h0B00_0000 + 32'(p * 256 + w);
                send_word(pkt[w], 2'b00, 1'b0, 0);
            end
            for (int w = 0; w < PW; w++) exp_pt[32*w +: 32] = pkt[w];
            exp_inv = 1'b0;
            chk("b2b_valid", KB'(aes_valid), KB'(1));
            chk("b2b_pt",    KB'(aes_shares_plaintext), KB'(exp_pt));
        end
        step();
        aes_ready = 1'b0;
        chk("b2b_done",      KB'(aes_valid), KB'(0));
        chk("b2b_cycles",    KB'(cyc - c0),  KB'(2 * (PW + 1)));
        chk("b2b_ready_low", KB'(nlow),      KB'(1));

        // Random packet mix
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            for (int w = 0; w < KW; w++) pkt[w] = $urandom;
            pkt_inv = 1'($urandom);
            run_packet((r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3, 2, int'($urandom_range(0, 3)));
        end
        chk("final_key", aes_shares_key, exp_key);
        chk("final_kl",  KB'(key_loaded), KB'(exp_kl));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_hpc_word_loader.md
# aes_hpc_word_loader

Upstream input stage for the masked 32-bit HPC AES top. It receives a narrow 32-bit word stream carrying shared key, shared plaintext and PRNG seed packets. It assembles them into the wide share-sequential buses and presents them on two valid/ready outputs: the AES input stream (plaintext + key + inverse) and the PRNG seed stream. The key is retained across operations, so one key load serves any number of plaintexts.

## Interface

Parameters:
- d, `DEFAULTSHARES (2): number of shares, d >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  32  input word.
- s_cmd  in  2  packet kind, sampled on the first word only: 00 plaintext, 01 key, 10 seed, 11 illegal.
- s_inverse  in  1  direction flag, sampled on the first plaintext word.
- s_valid  in  1  word valid.
- s_ready  out  1  word accepted when s_valid & s_ready.
- aes_shares_plaintext  out  128*d  share i at bits [128*i +: 128].
- aes_shares_key  out  256*d  share i at bits [256*i +: 256].
- aes_inverse  out  1  latched s_inverse.
- aes_valid  out  1  AES packet valid.
- aes_ready  in  1  AES core ready.
- seed  out  80  PRNG seed.
- seed_valid  out  1  seed valid.
- seed_ready  in  1  seed consumer ready.
- key_loaded  out  1  a complete key is held.
- err  out  1  one-cycle pulse on a rejected packet.

## Operation

- Packet lengths are fixed by kind: plaintext PW = 4*d words, key KW = 8*d words, seed SW = 3 words.
- Word w of a packet is written to bits [32*w +: 32] of its target register.
- Seed word 2 contributes s_data[15:0] to seed[79:64]; s_data[31:16] is ignored.
- FSM states: IDLE, LOAD_PT, LOAD_KEY, LOAD_SEED, SEND_AES, SEND_SEED, DRAIN.
- IDLE: s_ready=1. On a handshake, store the word as word 0, set cnt=1 and decode s_cmd.
  - 00: go to LOAD_PT and latch s_inverse.
  - 01: go to LOAD_KEY and clear key_loaded.
  - 10: go to LOAD_SEED.
  - 11: pulse err next cycle and stay in IDLE; the word is consumed.
- LOAD_x: s_ready=1. Each handshake writes word cnt, then cnt++. s_cmd and s_inverse are ignored in this state.
- Last word of each packet kind:
  - Plaintext: go to SEND_AES if key_loaded, otherwise pulse err and return to IDLE.
  - Key: set key_loaded and return to IDLE.
  - Seed: go to SEND_SEED.
- SEND_AES: aes_valid=1 and s_ready=0. On aes_ready, return to IDLE.
- SEND_SEED: seed_valid=1 and s_ready=0. On seed_ready, return to IDLE.
- Output registers are stable while the corresponding valid is high. The downstream latches at its handshake, so the key register may be overwritten only after that handshake.
- A plaintext packet that arrives with no key loaded is fully consumed before err pulses; no words are left in the stream.
- cnt width is clog2(8*d + 1). cnt resets to 0 on every return to IDLE. Wrap-around is impossible by construction.

## Timing

- Reset values: state IDLE, s_ready=1, aes_valid=0, seed_valid=0, key_loaded=0, err=0, cnt=0.
- On reset, all data registers (plaintext, key, seed, inverse) clear to 0. This zeroises shares.
- Reset mid-packet discards the partial packet. Reset during SEND_x drops valid in the next cycle with no handshake.
- Latency: aes_valid / seed_valid rise in the cycle after the last-word handshake.
- Valid outputs are registered, with no combinational path from aes_ready or seed_ready to valid or data. s_ready is decoded from state only.
- Throughput: one word per cycle while loading, plus one SEND cycle minimum. An encryption with the key already loaded costs 4*d + 1 cycles.
- If valid and ready are both high in the same cycle, the handshake completes and the state is IDLE on the next edge.
- err is high exactly one cycle, the cycle after the offending handshake.

## Structure

- Shared header aes_hpc_loader_defs.vh holds:
  - CMD_PT, CMD_KEY, CMD_SEED, CMD_BAD encodings;
  - state encodings;
  - word-count functions PW(d), KW(d), SW.
- Sub-module word_slot_reg: an N-word register with a write-enable and a word index, 32-bit word write. It is instantiated three times (plaintext, key, seed) and has a synchronous clear.
- The top-level FSM and counter live in aes_hpc_word_loader.

## Test plan

- d=2. Send a key packet of 16 words 0x00000000..0x0000000F, then a plaintext packet of 8 words 0x10..0x17 with s_inverse=1.
  - key_loaded rises after word 15.
  - aes_valid rises one cycle after word 7, with aes_shares_plaintext[255:224]=0x17, aes_shares_key[31:0]=0x0, and aes_inverse=1.
  - Hold aes_ready=0 for 5 cycles: the outputs stay stable and s_ready=0.
- Seed packet with words 0xAAAAAAAA, 0xBBBBBBBB, 0xFFFF1234.
  - Expect seed=0x1234_BBBBBBBB_AAAAAAAA.
  - seed_valid is held until seed_ready, then returns to IDLE.
- Plaintext packet sent after reset with no key.
  - All 8 words are accepted, err pulses once, aes_valid stays 0, and the state is IDLE.
- First word with s_cmd=11.
  - err pulses, the next word with s_cmd=00 starts a plaintext packet normally.
- Assert rst after word 5 of a key load.
  - key_loaded=0, the key register reads 0, and a fresh 16-word key loads correctly.
- Back-to-back traffic with s_valid always 1 and aes_ready always 1.
  - Two plaintexts complete in 2*(8+1) cycles.
  - s_ready is low for exactly one cycle between the two packets.
